fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues in-order requests to a variable-latency instruction memory.
- Buffers returned words in a prefetch queue and presents {instruction, PC+4} to IF/ID under a valid/ready handshake.
- Accepts a resolved redirect from the branch/jump select logic and discards every wrong-path word.

---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order requests to a
// variable-latency instruction memory, and buffers returned words for IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  input  logic        if_ready
);

  localparam int          PW   = $clog2(QDEPTH);
  localparam int          CW   = PW + 1;
  localparam logic [CW:0] W_QD = (CW + 1)'(QDEPTH);

  // Handshakes: a request is a single-cycle imem_req strobe with no back-pressure;
  // a response is a single-cycle imem_rvalid strobe; an IF/ID transfer happens
  // exactly on a cycle where if_valid and if_ready are both high.

  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc4   [QDEPTH];
  logic [31:0]   r_af      [QDEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_af_head;
  logic [PW-1:0] r_af_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_pc;
  logic          r_boot;

  logic [CW:0]   w_used;
  logic          w_issue;
  logic          w_resp;
  logic          w_push;
  logic          w_push_q;
  logic          w_pop;
  logic          w_nonempty;

  // Queued plus in-flight words never exceed QDEPTH, so a push always has room.
  assign w_used     = {1'b0, r_count} + {1'b0, r_out};
  assign w_issue    = !rst && !redirect_valid && !r_boot && (w_used < W_QD);
  assign w_resp     = imem_rvalid && (r_out != '0);
  assign w_push     = w_resp && (r_drop == '0);
  assign w_push_q   = w_push && !redirect_valid && !rst;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = if_valid && if_ready;

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign if_valid  = w_nonempty && !rst;
  assign if_instr  = w_nonempty ? r_q_instr[r_head] : 32'h0;
  assign if_pc4    = w_nonempty ? r_q_pc4[r_head]   : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_af_head <= '0;
      r_af_tail <= '0;
      r_out     <= '0;
      r_drop    <= '0;
      r_boot    <= 1'b1;
    end else begin
      r_boot <= 1'b0;
      r_out  <= r_out + CW'(w_issue) - CW'(w_resp);
      if (w_resp)  r_af_head <= r_af_head + PW'(1);
      if (w_issue) begin
        r_af_tail <= r_af_tail + PW'(1);
        r_pc      <= r_pc + 32'd4;
      end
      if (redirect_valid) begin
        // Every word still in flight after this cycle belongs to the wrong path.
        r_pc    <= redirect_target & 32'hFFFF_FFFC;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_drop  <= r_out - CW'(w_resp);
      end else begin
        if (w_pop)  r_head <= r_head + PW'(1);
        if (w_push) r_tail <= r_tail + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_push_q) begin
      r_q_instr[r_tail] <= imem_rdata;
      r_q_pc4[r_tail]   <= r_af[r_af_head] + 32'd4;
    end
    if (w_issue) r_af[r_af_tail] <= r_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model, in-order variable-latency
// memory environment, directed scenarios followed by randomized traffic.
module tb_fetch_unit;

  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_ready;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .if_ready(if_ready)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, limit 2000000 ns");
    $fatal(1, "watchdog");
  end

  // ---------------- model and environment state ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } word_t;
  typedef struct packed { logic [31:0] addr; logic stale; } fl_t;

  word_t       m_data[$];
  fl_t         m_infl[$];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_known;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          lat_min, lat_max;

  logic [63:0] exp_q[$];
  logic [63:0] act_q[$];
  int          act_cyc[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];

  int n_cmp, n_bad, cyc;

  logic        st_rst, st_redir, st_ready, st_force_rv;
  logic [31:0] st_tgt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] act_at(int i);
    if (i < act_q.size()) return act_q[i];
    return 'x;
  endfunction

  function automatic logic [63:0] exp_at(int i);
    if (i < exp_q.size()) return exp_q[i];
    return 'x;
  endfunction

  function automatic logic [31:0] req_at(int i);
    if (i < req_log.size()) return req_log[i];
    return 'x;
  endfunction

  function automatic int act_cyc_at(int i);
    if (i < act_cyc.size()) return act_cyc[i];
    return -1000;
  endfunction

  function automatic int req_cyc_at(int i);
    if (i < req_cyc.size()) return req_cyc[i];
    return -1000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    logic        e_req, e_valid, resp, popped, forced;
    logic [31:0] e_instr, e_pc4;
    fl_t         f;
    int          due;
    rst             = st_rst;
    redirect_valid  = st_redir;
    redirect_target = st_tgt;
    if_ready        = st_ready;
    forced          = 1'b0;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr_q[0];
    end else if (st_force_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      forced      = 1'b1;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    e_req   = !st_rst && !st_redir && !m_boot && (m_data.size() + m_infl.size() < QDEPTH);
    e_valid = !st_rst && (m_data.size() != 0);
    e_instr = (m_data.size() != 0) ? m_data[0].instr : 32'h0;
    e_pc4   = (m_data.size() != 0) ? m_data[0].pc4   : 32'h0;
    if (m_known) begin
      check("imem_req", 64'(imem_req), 64'(e_req));
      if (e_req) check("imem_addr", 64'(imem_addr), 64'(m_pc));
      check("if_valid", 64'(if_valid), 64'(e_valid));
      check("if_instr", 64'(if_instr), 64'(e_instr));
      check("if_pc4", 64'(if_pc4), 64'(e_pc4));
    end
    if (if_valid === 1'b1 && if_ready) begin
      act_q.push_back({if_instr, if_pc4});
      act_cyc.push_back(cyc);
    end
    if (e_valid && st_ready) exp_q.push_back({e_instr, e_pc4});
    if (imem_req === 1'b1) begin
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end
    // memory environment follows the requests the DUT actually made
    if (imem_rvalid && !forced) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (st_rst) begin
      mem_addr_q.delete();
      mem_due_q.delete();
    end
    if (imem_req === 1'b1) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (mem_due_q.size() > 0 && due <= mem_due_q[$]) due = mem_due_q[$] + 1;
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(due);
    end
    // reference model: in-flight words tagged stale by a redirect are discarded
    if (st_rst) begin
      m_pc = RESET_PC;
      m_data.delete();
      m_infl.delete();
      m_boot  = 1'b1;
      m_known = 1'b1;
    end else begin
      resp   = imem_rvalid && (m_infl.size() > 0);
      popped = e_valid && st_ready;
      if (st_redir) begin
        if (resp) void'(m_infl.pop_front());
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_data.delete();
        m_pc = st_tgt & 32'hFFFF_FFFC;
      end else begin
        if (popped) void'(m_data.pop_front());
        if (resp) begin
          f = m_infl.pop_front();
          if (!f.stale) m_data.push_back('{instr: imem_rdata, pc4: f.addr + 32'd4});
        end
        if (e_req) begin
          m_infl.push_back('{addr: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      m_boot = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_idle();
    st_rst = 1'b0; st_redir = 1'b0; st_tgt = 32'h0; st_ready = 1'b1; st_force_rv = 1'b0;
  endtask

  task automatic do_reset();
    st_rst = 1'b1;
    step();
    st_rst = 1'b0;
  endtask

  task automatic clear_logs();
    exp_q.delete(); act_q.delete(); act_cyc.delete(); req_log.delete(); req_cyc.delete();
  endtask

  // ---------------- stimulus and final report ----------------
  initial begin
    int base, idx, rcyc, tries;
    logic [31:0] tgts[2];
    n_cmp = 0; n_bad = 0; cyc = 0; m_known = 1'b0; m_boot = 1'b0; m_pc = 32'h0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; if_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    lat_min = 1; lat_max = 1;
    set_idle();
    @(posedge clk);
    #1;

    // free-run, 1-cycle memory
    do_reset();
    clear_logs();
    run(12);
    check("first_issue_after_boot", 64'(req_cyc_at(0) - (act_cyc_at(0) - 2)), 64'(0));
    check("first_valid_latency", 64'(act_cyc_at(0) - req_cyc_at(0)), 64'(2));
    check("free_w0", act_at(0), {32'h0, 32'h4});
    check("free_w1", act_at(1), {32'h4, 32'h8});
    check("free_w2", act_at(2), {32'h8, 32'hC});
    check("free_back_to_back", 64'(act_cyc_at(2) - act_cyc_at(0)), 64'(2));
    check("model_free_w0", exp_at(0), {32'h0, 32'h4});

    // stall with if_ready low
    set_idle();
    st_ready = 1'b0;
    do_reset();
    clear_logs();
    run(12);
    check("stall_req_count", 64'(req_log.size()), 64'(4));
    check("stall_no_delivery", 64'(act_q.size()), 64'(0));
    check("stall_head_instr", 64'(if_instr), 64'(32'h0));
    check("stall_head_pc4", 64'(if_pc4), 64'(32'h4));
    st_ready = 1'b1;
    run(8);
    for (int i = 0; i < 5; i++)
      check("stall_release_order", act_at(i), {32'(i * 4), 32'(i * 4 + 4)});

    // redirect with two requests outstanding, 3-cycle memory
    tgts[0] = 32'h100;
    tgts[1] = 32'h103;
    lat_min = 3; lat_max = 3;
    for (int t = 0; t < 2; t++) begin
      set_idle();
      do_reset();
      run(3);
      check("redir_outstanding", 64'(m_infl.size()), 64'(2));
      clear_logs();
      st_redir = 1'b1; st_tgt = tgts[t];
      step();
      st_redir = 1'b0;
      run(12);
      check("redir_first_word", act_at(0), {32'h100, 32'h104});
      check("redir_first_req", 64'(req_at(0)), 64'(32'h100));
      check("model_redir_first", exp_at(0), {32'h100, 32'h104});
    end

    // redirect in the same cycle as a response and a pop
    lat_min = 1; lat_max = 1;
    set_idle();
    do_reset();
    clear_logs();
    tries = 0;
    while (act_q.size() < 3 && tries < 20) begin
      step();
      tries++;
    end
    check("collide_setup_bound", 64'(act_q.size()), 64'(3));
    idx  = req_log.size();
    rcyc = cyc;
    st_redir = 1'b1; st_tgt = 32'h200;
    step();
    st_redir = 1'b0;
    run(6);
    check("collide_popped_word", act_at(3), {32'hC, 32'h10});
    check("collide_next_word", act_at(4), {32'h200, 32'h204});
    check("collide_resume_addr", 64'(req_at(idx)), 64'(32'h200));
    check("collide_resume_cycle", 64'(req_cyc_at(idx) - rcyc), 64'(1));

    // PC wrap
    set_idle();
    do_reset();
    clear_logs();
    st_redir = 1'b1; st_tgt = 32'hFFFF_FFF8;
    step();
    st_redir = 1'b0;
    run(8);
    check("wrap_w0", act_at(0), {32'hFFFF_FFF8, 32'hFFFF_FFFC});
    check("wrap_w1", act_at(1), {32'hFFFF_FFFC, 32'h0});
    check("wrap_w2", act_at(2), {32'h0, 32'h4});

    // reset mid-operation with two queued and two outstanding
    lat_min = 3; lat_max = 3;
    set_idle();
    st_ready = 1'b0;
    do_reset();
    tries = 0;
    while (!(m_data.size() == 2 && m_infl.size() == 2) && tries < 30) begin
      step();
      tries++;
    end
    check("midreset_setup_bound", 64'(m_data.size() * 10 + m_infl.size()), 64'(22));
    clear_logs();
    st_force_rv = 1'b1;
    do_reset();
    step();
    st_force_rv = 1'b0;
    st_ready = 1'b1;
    run(12);
    check("midreset_w0", act_at(0), {RESET_PC, RESET_PC + 32'd4});
    check("midreset_w1", act_at(1), {RESET_PC + 32'd4, RESET_PC + 32'd8});

    // randomized traffic
    set_idle();
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      lat_min = $urandom_range(1, 3);
      lat_max = lat_min + $urandom_range(0, 3);
      base = $urandom_range(1, 4);
      for (int i = 0; i < 250; i++) begin
        st_ready = ($urandom_range(0, 4) < base);
        st_redir = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 3) == 0) st_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else st_tgt = $urandom;
        st_rst = ($urandom_range(0, 249) == 0);
        step();
      end
    end
    set_idle();
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
